// File: rtl/i2c_pkg.sv
// Shared I2C definitions: transmit FSM states, frame limits and ACK polarity.
package i2c_pkg;

    localparam int unsigned MAX_BYTES = 4;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SHIFT,
        TX_ACKREL,
        TX_ACKWAIT
    } tx_state_e;

endpackage

// File: rtl/i2c_tx_pingpong.sv
// Two-entry ping-pong frame store for the I2C transmit shifter.
module i2c_tx_pingpong
    import i2c_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] wr_data,
    input  logic [3:0]    wr_size,
    input  logic          wr_en,
    input  logic          rd_free,
    output logic [DW-1:0] rd_data,
    output logic [3:0]    rd_size,
    output logic          rd_full,
    output logic          wr_ready
);

    logic [DW-1:0] data_q [2];
    logic [DW-1:0] data_d [2];
    logic [3:0]    size_q [2];
    logic [3:0]    size_d [2];
    logic [1:0]    full_q;
    logic [1:0]    full_d;
    logic          wr_q;
    logic          wr_d;
    logic          rd_q;
    logic          rd_d;

    // Write and free use separate pointers; a write only targets an empty
    // slot and a free only a full one, so both may act in the same cycle.
    always_comb begin
        data_d = data_q;
        size_d = size_q;
        full_d = full_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        if (wr_en) begin
            data_d[wr_q] = wr_data;
            size_d[wr_q] = wr_size;
            full_d[wr_q] = 1'b1;
            wr_d         = ~wr_q;
        end
        if (rd_free) begin
            full_d[rd_q] = 1'b0;
            rd_d         = ~rd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            size_q[0] <= '0;
            size_q[1] <= '0;
            full_q    <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
        end else begin
            data_q <= data_d;
            size_q <= size_d;
            full_q <= full_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
        end
    end

    assign rd_data  = data_q[rd_q];
    assign rd_size  = size_q[rd_q];
    assign rd_full  = full_q[rd_q];
    assign wr_ready = ~full_q[wr_q];

endmodule

// File: rtl/i2c_tx_shift.sv
// I2C transmit shifter: serialises queued frames MSB-first onto SDA and
// evaluates the slave ACK after every byte.
module i2c_tx_shift
    import i2c_pkg::*;
#(
    parameter int unsigned MAX_BYTES = i2c_pkg::MAX_BYTES,
    parameter int unsigned CNT_W     = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [MAX_BYTES*8-1:0] TXData,
    input  logic [3:0]             Size,
    input  logic                   LoadTXD,
    output logic                   TXReady,
    output logic                   SizeErr,
    input  logic                   StartTX,
    input  logic                   ShiftEn,
    input  logic                   AckSample,
    input  logic                   AckIn,
    output logic                   TXOut,
    output logic                   TXBusy,
    output logic [CNT_W-1:0]       TXcount,
    output logic                   ByteDone,
    output logic                   FrameDone,
    output logic                   NackErr
);

    localparam int unsigned DW    = MAX_BYTES * 8;
    localparam int unsigned IDX_W = $clog2(DW);

    tx_state_e        state_q, state_d;
    logic             txout_q, txout_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             byte_done_q, byte_done_d;
    logic             frame_done_q, frame_done_d;
    logic             nack_err_q, nack_err_d;
    logic             size_err_q, size_err_d;

    logic             size_bad;
    logic             load_ok;
    logic             free;
    logic [CNT_W-1:0] bit_idx;
    logic [DW-1:0]    rd_data;
    logic [3:0]       rd_size;
    logic             rd_full;
    logic             tx_ready;

    i2c_tx_pingpong #(
        .DW (DW)
    ) u_pingpong (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (TXData),
        .wr_size  (Size),
        .wr_en    (load_ok),
        .rd_free  (free),
        .rd_data  (rd_data),
        .rd_size  (rd_size),
        .rd_full  (rd_full),
        .wr_ready (tx_ready)
    );

    always_comb begin
        state_d      = state_q;
        txout_d      = txout_q;
        busy_d       = busy_q;
        count_d      = count_q;
        byte_done_d  = 1'b0;
        frame_done_d = 1'b0;
        nack_err_d   = 1'b0;
        free         = 1'b0;

        size_bad   = (Size == 4'd0) || (Size > 4'(MAX_BYTES));
        load_ok    = LoadTXD && tx_ready && !size_bad;
        size_err_d = LoadTXD && size_bad;
        bit_idx    = count_q - CNT_W'(1);

        case (state_q)
            TX_IDLE: begin
                txout_d = 1'b1;
                if (StartTX && rd_full) begin
                    state_d = TX_SHIFT;
                    busy_d  = 1'b1;
                    count_d = CNT_W'({rd_size, 3'b000});
                end
            end
            TX_SHIFT: begin
                if (ShiftEn) begin
                    txout_d = rd_data[bit_idx[IDX_W-1:0]];
                    count_d = bit_idx;
                    if (bit_idx[2:0] == 3'd0) begin
                        state_d = TX_ACKREL;
                    end
                end
            end
            TX_ACKREL: begin
                if (ShiftEn) begin
                    txout_d = 1'b1;
                    state_d = TX_ACKWAIT;
                end
            end
            TX_ACKWAIT: begin
                // AckSample has priority; a coincident ShiftEn is dropped.
                if (AckSample) begin
                    if (AckIn == ACK) begin
                        byte_done_d = 1'b1;
                        if (count_q == '0) begin
                            frame_done_d = 1'b1;
                            free         = 1'b1;
                            busy_d       = 1'b0;
                            state_d      = TX_IDLE;
                        end else begin
                            state_d = TX_SHIFT;
                        end
                    end else begin
                        nack_err_d = 1'b1;
                        free       = 1'b1;
                        count_d    = '0;
                        busy_d     = 1'b0;
                        txout_d    = 1'b1;
                        state_d    = TX_IDLE;
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= TX_IDLE;
            txout_q      <= 1'b1;
            busy_q       <= 1'b0;
            count_q      <= '0;
            byte_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            nack_err_q   <= 1'b0;
            size_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            txout_q      <= txout_d;
            busy_q       <= busy_d;
            count_q      <= count_d;
            byte_done_q  <= byte_done_d;
            frame_done_q <= frame_done_d;
            nack_err_q   <= nack_err_d;
            size_err_q   <= size_err_d;
        end
    end

    assign TXReady   = tx_ready;
    assign SizeErr   = size_err_q;
    assign TXOut     = txout_q;
    assign TXBusy    = busy_q;
    assign TXcount   = count_q;
    assign ByteDone  = byte_done_q;
    assign FrameDone = frame_done_q;
    assign NackErr   = nack_err_q;

endmodule

// File: tb/tb_i2c_tx_shift.sv
// Bench for i2c_tx_shift: directed scenarios plus random loads/sends against a frame-queue model.
module tb_i2c_tx_shift;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] TXData;
    logic [3:0]  Size;
    logic        LoadTXD;
    logic        TXReady;
    logic        SizeErr;
    logic        StartTX;
    logic        ShiftEn;
    logic        AckSample;
    logic        AckIn;
    logic        TXOut;
    logic        TXBusy;
    logic [6:0]  TXcount;
    logic        ByteDone;
    logic        FrameDone;
    logic        NackErr;

    typedef struct {
        logic [31:0] data;
        int          size;
    } frame_t;

    frame_t q[$];
    int n_total = 0;
    int n_pass  = 0;

    i2c_tx_shift #(
        .MAX_BYTES (4),
        .CNT_W     (7)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .TXData    (TXData),
        .Size      (Size),
        .LoadTXD   (LoadTXD),
        .TXReady   (TXReady),
        .SizeErr   (SizeErr),
        .StartTX   (StartTX),
        .ShiftEn   (ShiftEn),
        .AckSample (AckSample),
        .AckIn     (AckIn),
        .TXOut     (TXOut),
        .TXBusy    (TXBusy),
        .TXcount   (TXcount),
        .ByteDone  (ByteDone),
        .FrameDone (FrameDone),
        .NackErr   (NackErr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_idle_pulses(input string tag);
        check({tag, "_bytedone"}, ByteDone, 0);
        check({tag, "_framedone"}, FrameDone, 0);
        check({tag, "_nackerr"}, NackErr, 0);
    endtask

    task automatic load(input logic [31:0] d, input int sz);
        bit legal;
        bit ready;
        frame_t f;
        legal = (sz >= 1) && (sz <= 4);
        ready = (q.size() < 2);
        TXData  = d;
        Size    = 4'(sz);
        LoadTXD = 1'b1;
        tick();
        LoadTXD = 1'b0;
        if (legal && ready) begin
            f.data = d;
            f.size = sz;
            q.push_back(f);
        end
        check("size_err", SizeErr, !legal);
        check("tx_ready_after_load", TXReady, q.size() < 2);
    endtask

    task automatic shift_strobe();
        ShiftEn = 1'b1;
        tick();
        ShiftEn = 1'b0;
    endtask

    // Send the oldest queued frame; nack_byte < 0 means every byte is ACKed.
    task automatic send(input int nack_byte, input bit quirks);
        frame_t f;
        int     b;
        bit     last;
        if (q.size() == 0) begin
            StartTX = 1'b1;
            tick();
            StartTX = 1'b0;
            check("start_empty_busy", TXBusy, 0);
            check("start_empty_count", TXcount, 0);
            return;
        end
        f = q[0];
        StartTX = 1'b1;
        tick();
        StartTX = 1'b0;
        check("start_busy", TXBusy, 1);
        check("start_count", TXcount, f.size * 8);
        for (int k = 0; k < f.size; k++) begin
            if (quirks) begin
                AckSample = 1'b1;
                AckIn     = 1'($urandom_range(0, 1));
                StartTX   = 1'b1;
                tick();
                AckSample = 1'b0;
                StartTX   = 1'b0;
                check_idle_pulses("stray_ack");
                check("stray_ack_count", TXcount, (f.size - k) * 8);
                check("stray_ack_busy", TXBusy, 1);
            end
            for (int j = 0; j < 8; j++) begin
                b = (f.size - k) * 8 - 1 - j;
                shift_strobe();
                check("bit", TXOut, f.data[b]);
                check("bit_count", TXcount, b);
                if ($urandom_range(0, 3) == 0) begin
                    tick();
                    check("bit_hold", TXOut, f.data[b]);
                end
            end
            shift_strobe();
            check("release", TXOut, 1);
            check_idle_pulses("release");
            last = (k == f.size - 1);
            AckSample = 1'b1;
            AckIn     = (k == nack_byte);
            ShiftEn   = quirks;
            tick();
            AckSample = 1'b0;
            ShiftEn   = 1'b0;
            if (k == nack_byte) begin
                void'(q.pop_front());
                check("nack_err", NackErr, 1);
                check("nack_bytedone", ByteDone, 0);
                check("nack_framedone", FrameDone, 0);
                check("nack_count", TXcount, 0);
                check("nack_txout", TXOut, 1);
                check("nack_busy", TXBusy, 0);
                check("nack_ready", TXReady, q.size() < 2);
                tick();
                check_idle_pulses("after_nack");
                return;
            end
            check("ack_bytedone", ByteDone, 1);
            check("ack_framedone", FrameDone, last);
            check("ack_nackerr", NackErr, 0);
            check("ack_txout", TXOut, 1);
            if (last) begin
                void'(q.pop_front());
                check("done_busy", TXBusy, 0);
                check("done_ready", TXReady, q.size() < 2);
            end else begin
                check("ack_busy", TXBusy, 1);
            end
            tick();
            check_idle_pulses("after_ack");
        end
    endtask

    initial begin
        int sz;
        int nk;
        rst       = 1'b1;
        TXData    = '0;
        Size      = '0;
        LoadTXD   = 1'b0;
        StartTX   = 1'b0;
        ShiftEn   = 1'b0;
        AckSample = 1'b0;
        AckIn     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_txout", TXOut, 1);
        check("rst_ready", TXReady, 1);
        check("rst_busy", TXBusy, 0);
        check("rst_count", TXcount, 0);
        check("rst_sizeerr", SizeErr, 0);
        check_idle_pulses("rst");

        // Single byte frame.
        load(32'h0000_00A5, 1);
        send(-1, 1'b0);

        // Two frames queued, third refused, then drained in order.
        load(32'h1234_5678, 4);
        load(32'h0000_BEEF, 2);
        check("both_full_ready", TXReady, 0);
        load(32'h0000_DEAD, 1);
        send(-1, 1'b0);
        check("ready_after_first", TXReady, 1);
        send(-1, 1'b1);

        // NACK on second byte of three, then a new frame goes out normally.
        load(32'h00C0_FFEE, 3);
        send(1, 1'b0);
        load(32'h0000_003C, 1);
        send(-1, 1'b0);

        // Illegal sizes, then StartTX with nothing queued.
        load(32'h0000_0011, 0);
        load(32'h0000_0022, 5);
        check("sizeerr_ready", TXReady, 1);
        send(-1, 1'b0);

        // Reset in the middle of a frame.
        load(32'h0000_F00D, 2);
        StartTX = 1'b1;
        tick();
        StartTX = 1'b0;
        repeat (5) shift_strobe();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q.delete();
        check("midrst_txout", TXOut, 1);
        check("midrst_busy", TXBusy, 0);
        check("midrst_ready", TXReady, 1);
        check("midrst_count", TXcount, 0);
        check_idle_pulses("midrst");
        send(-1, 1'b0);

        // Random mix of loads and sends.
        repeat (40) begin
            if ($urandom_range(0, 1) == 0) begin
                sz = (q.size() < 2) ? int'($urandom_range(0, 5)) : int'($urandom_range(1, 4));
                load($urandom, sz);
            end else begin
                nk = -1;
                if (q.size() != 0 && $urandom_range(0, 3) == 0) begin
                    nk = int'($urandom_range(0, q[0].size - 1));
                end
                send(nk, 1'($urandom_range(0, 1)));
            end
        end
        while (q.size() != 0) send(-1, 1'b0);
        check("final_ready", TXReady, 1);
        check("final_busy", TXBusy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
